uart_tx_scheduler: RTL and testbench

- Shares one uart_simplex transmitter between NUM_REQ byte producers using round-robin arbitration.
- Sequences the transmitter by:
  - issuing a one-cycle TX_ENABLE strobe with the granted byte;
  - blocking new launches until the full frame time has elapsed, because uart_simplex has no busy/done output.
- Sits between the producer logic and the uart_simplex instance.
- Outputs wire directly to the transmitter's i_TX_ENABLE and i_DATA_IN.

---
 rtl/uart_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one uart_simplex
// transmitter between NUM_REQ byte producers. The transmitter has no busy or
// done output, so a launch is followed by a counted hold of
// FRAME_BITS*CLKS_PER_BIT cycles before the next arbitration.
//
// Optional feature macro: UART_SCHED_LOCK_EN (burst lock, keeps the grant
// while i_LOCK and i_REQ of the current owner stay high).
//
// Ports:
//   i_CLK        clock, rising edge
//   i_RST        asynchronous active-high reset
//   i_REQ        per-requester level request, held until acknowledged
//   i_DATA       requester n byte at [8n+7:8n]
//   i_LOCK       per-requester burst lock (UART_SCHED_LOCK_EN only)
//   o_ACK        one-hot, one-cycle byte-captured pulse
//   o_TX_ENABLE  one-cycle launch strobe to transmitter i_TX_ENABLE
//   o_DATA_OUT   byte to transmitter i_DATA_IN, stable for the whole frame
//   o_BUSY       high while launching or holding for the frame
//   o_GRANT_ID   index of current or last granted requester
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FRAME_BITS   = 10
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic [NUM_REQ-1:0]     i_REQ,
  input  logic [NUM_REQ*8-1:0]   i_DATA,
  input  logic [NUM_REQ-1:0]     i_LOCK,
  output logic [NUM_REQ-1:0]     o_ACK,
  output logic                   o_TX_ENABLE,
  output logic [7:0]             o_DATA_OUT,
  output logic                   o_BUSY,
  output logic [ID_W-1:0]        o_GRANT_ID
);

  localparam int unsigned FRAME_CYC = FRAME_BITS * CLKS_PER_BIT;
  localparam int unsigned CNT_W     = $clog2(FRAME_CYC) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          data_q, data_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     grant_q, grant_d;

  logic [7:0]          req_byte [NUM_REQ];
  logic                win_vld;
  logic [ID_W-1:0]     win_id;

`ifndef UART_SCHED_LOCK_EN
  // Lock inputs are intentionally unused in the pure round-robin build.
  logic unused_lock;
  assign unused_lock = ^i_LOCK;
`endif

  // Split the flat data bus into per-requester bytes.
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_bytes
    assign req_byte[n] = i_DATA[8*n +: 8];
  end

  // Round-robin search: first set request upward from grant_q+1, circularly.
  always_comb begin
    win_vld = 1'b0;
    win_id  = grant_q;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(grant_q) + i) % NUM_REQ;
      if (!win_vld && i_REQ[ID_W'(idx)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      tx_en_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      tx_en_q <= tx_en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    tx_en_d = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          ack_d   = NUM_REQ'(1) << win_id;
          data_d  = req_byte[win_id];
          grant_d = win_id;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Strobe is registered, so it lands in the cycle after the ack.
        tx_en_d = 1'b1;
        cnt_d   = CNT_W'(FRAME_CYC - 1);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
`ifdef UART_SCHED_LOCK_EN
          // Locked owner with a pending byte keeps the transmitter.
          if (i_LOCK[grant_q] && i_REQ[grant_q]) begin
            ack_d   = NUM_REQ'(1) << grant_q;
            data_d  = req_byte[grant_q];
            state_d = ST_LAUNCH;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  assign o_ACK       = ack_q;
  assign o_TX_ENABLE = tx_en_q;
  assign o_DATA_OUT  = data_q;
  assign o_BUSY      = busy_q;
  assign o_GRANT_ID  = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (NUM_REQ=4, CLKS_PER_BIT=1,
// FRAME_BITS=10). The lock scenario is compiled in with UART_SCHED_LOCK_EN.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic        tx_en;
  logic [7:0]  data_out;
  logic        busy;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  uart_tx_scheduler #(
    .NUM_REQ(4), .ID_W(2), .CLKS_PER_BIT(1), .FRAME_BITS(10)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_DATA(data), .i_LOCK(lock),
    .o_ACK(ack), .o_TX_ENABLE(tx_en), .o_DATA_OUT(data_out),
    .o_BUSY(busy), .o_GRANT_ID(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  // Steps until the next launch strobe; records its cycle and byte.
  task automatic wait_launch(output int c, output logic [7:0] d);
    int n;
    n = 0;
    c = -1;
    d = 8'h00;
    while (n < 40) begin
      step();
      n++;
      if (tx_en) begin
        c = cyc;
        d = data_out;
        break;
      end
    end
    chk("launch_seen", 32'(c >= 0), 32'd1);
  endtask

  int         lc [5];
  logic [7:0] ld [5];
  int         ack_cyc;
  int         busy_cnt;

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0;
    lock = 4'b0000;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_data", 32'(data_out), 32'h00);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_quiet", {27'd0, tx_en, ack}, 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Single byte from requester 2
    data[23:16] = 8'h2A;
    req = 4'b0100;
    step();
    ack_cyc = cyc;
    chk("single_ack", 32'(ack), 32'h4);
    chk("single_tx_early", 32'(tx_en), 32'd0);
    chk("single_grant", 32'(grant), 32'd2);
    req = 4'b0000;
    step();
    chk("single_ack_one_cycle", 32'(ack), 32'h0);
    chk("single_tx", 32'(tx_en), 32'd1);
    chk("single_data", 32'(data_out), 32'h2A);
    busy_cnt = 2;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!busy) break;
      busy_cnt++;
      chk("single_tx_once", 32'(tx_en), 32'd0);
      chk("single_data_hold", 32'(data_out), 32'h2A);
    end
    chk("single_busy_len", 32'(busy_cnt), 32'd11);
    data[7:0] = 8'h55;
    req = 4'b0001;
    step();
    chk("next_accept_ack", 32'(ack), 32'h1);
    chk("next_accept_gap", 32'(cyc - ack_cyc), 32'd12);
    req = 4'b0000;
    wait_idle();

    // Round robin from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    data = 32'h13121110;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_launch(lc[k], ld[k]);
    chk("rr_d0", 32'(ld[0]), 32'h10);
    chk("rr_d1", 32'(ld[1]), 32'h11);
    chk("rr_d2", 32'(ld[2]), 32'h12);
    chk("rr_d3", 32'(ld[3]), 32'h13);
    chk("rr_d4", 32'(ld[4]), 32'h10);
    for (int k = 1; k < 5; k++) chk("rr_gap", 32'(lc[k] - lc[k-1]), 32'd12);
    req = 4'b0000;
    wait_idle();

    // Late request from 1, withdrawn request from 3
    req = 4'b0001;
    step();
    chk("late_ack0", 32'(ack), 32'h1);
    req = 4'b0000;
    step();
    chk("late_tx", 32'(tx_en), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_no_ack_a", 32'(ack), 32'h0);
    end
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_no_ack_b", 32'(ack), 32'h0);
    end
    req = 4'b0010;
    for (int i = 0; i < 20 && busy; i++) begin
      step();
      chk("late_no_ack_hold", 32'(ack), 32'h0);
    end
    chk("late_idle", 32'(busy), 32'd0);
    step();
    chk("late_ack1", 32'(ack), 32'h2);
    req = 4'b0000;
    wait_idle();
    for (int i = 0; i < 15; i++) begin
      step();
      chk("withdrawn_never_acked", 32'(ack), 32'h0);
    end

    // Asynchronous reset mid-frame
    data = 32'h002A005A;
    req = 4'b0100;
    step();
    chk("mid_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'h00);
    chk("mid_rst_grant", 32'(grant), 32'd3);
    step();
    rst = 1'b0;
    req = 4'b0101;
    step();
    chk("mid_first_ack", 32'(ack), 32'h1);
    chk("mid_first_data", 32'(data_out), 32'h5A);
    req = 4'b0000;
    wait_idle();

`ifdef UART_SCHED_LOCK_EN
    // Burst lock on requester 0
    begin
      int nl;
      int acks0;
      nl = 0;
      acks0 = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      data = 32'h0000B1A0;
      req  = 4'b0011;
      lock = 4'b0001;
      for (int k = 0; k < 200 && nl < 4; k++) begin
        step();
        if (ack[0]) begin
          acks0++;
          data[7:0] = 8'(8'hA0 + acks0);
          if (acks0 == 3) begin
            lock[0] = 1'b0;
            req[0]  = 1'b0;
          end
        end
        if (ack[1]) req[1] = 1'b0;
        if (tx_en) begin
          lc[nl] = cyc;
          ld[nl] = data_out;
          nl++;
        end
      end
      chk("lock_launches", 32'(nl), 32'd4);
      chk("lock_d0", 32'(ld[0]), 32'hA0);
      chk("lock_d1", 32'(ld[1]), 32'hA1);
      chk("lock_d2", 32'(ld[2]), 32'hA2);
      chk("lock_d3", 32'(ld[3]), 32'hB1);
      chk("lock_gap1", 32'(lc[1] - lc[0]), 32'd11);
      chk("lock_gap2", 32'(lc[2] - lc[1]), 32'd11);
      chk("lock_gap3", 32'(lc[3] - lc[2]), 32'd12);
      wait_idle();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
